alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Issue/writeback controller that sits directly upstream and downstream of the 4-bit logic/arith units (AND, OR, XOR, ADD).
- Holds the 4x4-bit register file.
- Accepts one instruction at a time over a valid/ready handshake, reads Rd1/Rd2, and pulses exactly one unit enable.
- Captures the unit result and writes it back to the destination register.

Parameters:
- DATA_W, 4, operand/result width; must match the unit width.
- REG_CNT, 4, number of registers.
- ADDR_W, 2, register address width; equals log2(REG_CNT).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  controller can accept an instruction.
- instr  input  8  {op[7:6], rd[5:4], rs1[3:2], rs2[1:0]}.
- ld_en  input  1  direct register load (initialisation).
- ld_addr  input  ADDR_W  load target register.
- ld_data  input  DATA_W  load value.
- Rd1  output  DATA_W  operand 1 to the units.
- Rd2  output  DATA_W  operand 2 to the units.
- en_and, en_orr, en_xor, en_add  output  1 each  one-hot unit enables.
- alu_result  input  DATA_W  bitwise OR of all unit outputs; disabled units drive 0.
- wb_data  output  DATA_W  value written back.
- wb_addr  output  ADDR_W  register written back.
- done  output  1  one-cycle pulse in the writeback cycle.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; all registers clear to 0.
  - Rd1, Rd2, wb_data, wb_addr and captured result clear to 0.
  - All enables and done are 0.
  - Reset overrides everything, including mid-operation: the in-flight instruction is dropped and no writeback occurs.
- States: IDLE -> READ -> EXEC -> WB -> IDLE. There are no other transitions, except reset to IDLE.
- instr_ready = (state==IDLE) && !ld_en. An instruction is accepted when instr_valid && instr_ready at an edge; op, rd, rs1 and rs2 are latched.
- IDLE with ld_en=1: regfile[ld_addr] <= ld_data. A load always wins over an offered instruction, which stays pending because ready is low.
- ld_en is ignored outside IDLE.
- READ: at the end of the cycle, Rd1 <= regfile[rs1] and Rd2 <= regfile[rs2].
- EXEC:
  - Exactly one enable is high for one cycle, selected by op: 00 AND, 01 ORR, 10 XOR, 11 ADD. ADD is modulo 2^DATA_W, with the carry dropped by the unit.
  - At the end of the cycle the result register <= alu_result.
- WB:
  - done=1; wb_data = captured result; wb_addr = rd.
  - At the end of the cycle, regfile[rd] <= captured result.
- Timing: with the accept edge at the end of cycle 0:
  - READ is cycle 1.
  - The enable is high in cycle 2.
  - done is high in cycle 3.
  - The register updates at the end of cycle 3.
  - instr_ready is high again in cycle 4.
  - Throughput is one instruction per 4 cycles.
- Rd1/Rd2 hold their last values outside READ/EXEC; the units gate their outputs with en, so held operands are harmless.
- Hazards:
  - rd equal to rs1/rs2 is legal, because operands are read before writeback.
  - Back-to-back dependent instructions always see the prior writeback, since accept occurs only after WB.
- wb_data and wb_addr hold their values after WB; only done pulses.
- dbg_data is combinational and reflects a write on the cycle after the write edge.

Decomposition:
- Shared package:
  - Opcode constants OP_AND=2'b00, OP_ORR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11.
  - State encoding IDLE/READ/EXEC/WB.
  - Instruction field bit positions.
  - DATA_W/ADDR_W defaults.
- One sub-module: alu_regfile.
  - REG_CNT x DATA_W registers, synchronous reset.
  - One write port, muxed between load and writeback by the controller.
  - Three combinational read ports: rs1, rs2, dbg.
- The controller FSM, operand registers and result capture stay in alu_issue_ctrl.

Test Plan:
- Load and OR:
  - Stimulus: load r1=4'b1010, r2=4'b0101; issue OR rd=3, rs1=1, rs2=2; unit model returns Rd1|Rd2.
  - Response: en_orr high in exactly one cycle (cycle 2 after accept), all other enables 0; done in cycle 3 with wb_data=4'hF, wb_addr=3; dbg r3 reads 4'hF.
- Opcode sweep with r1=4'hC, r2=4'hA:
  - AND -> 4'h8.
  - XOR -> 4'h6.
  - ADD -> 4'h6 (carry dropped).
  - Each case: only the matching enable fires.
- In-place operation: r0=4'h7, issue ADD rd=0, rs1=0, rs2=0 -> r0=4'hE; repeat -> r0=4'hC.
- Handshake:
  - Hold instr_valid high continuously: instr_ready high only in IDLE cycles; one accept per 4 cycles.
  - With ld_en and instr_valid together: load performed, instr_ready=0, instruction accepted the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst during EXEC.
  - Response: the next cycle is IDLE, done never pulses, every register reads 0, and all enables are 0.
- ld_en outside IDLE: assert ld_en=1, ld_addr=2, ld_data=4'h9 during READ -> r2 unchanged, FSM unaffected.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcodes, FSM encoding and instruction layout for the 4-bit ALU issue controller.
package alu_issue_ctrl_pkg;

   localparam int DATA_W_DEF  = 4;
   localparam int ADDR_W_DEF  = 2;
   localparam int REG_CNT_DEF = 4;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_ORR = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   localparam int INSTR_W = 8;
   localparam int OP_LSB  = 6;
   localparam int RD_LSB  = 4;
   localparam int RS1_LSB = 2;
   localparam int RS2_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_e;

   typedef struct packed {
      logic [1:0] op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
   } instr_t;

   // Enable vector bit order matches the opcode value: {add, xor, orr, and}.
   function automatic logic [3:0] op_to_en(input logic [1:0] op);
      logic [3:0] en;
      en = 4'b0000;
      case (op)
         OP_AND:  en = 4'b0001;
         OP_ORR:  en = 4'b0010;
         OP_XOR:  en = 4'b0100;
         OP_ADD:  en = 4'b1000;
         default: en = 4'b0000;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// REG_CNT x DATA_W register file: one write port, three combinational read ports.
// Writes land at the clock edge; reads see them the following cycle.
module alu_regfile
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_CNT = REG_CNT_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [DATA_W-1:0] mem_q [REG_CNT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_CNT; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o   = mem_q[raddr1_i];
   assign rdata2_o   = mem_q[raddr2_i];
   assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the AND/OR/XOR/ADD units: IDLE->READ->EXEC->WB, one instruction per 4 cycles.
// instr_ready is high only in IDLE with no register load pending; loads outside IDLE are ignored.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_CNT = REG_CNT_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic               ld_en,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
   output logic [DATA_W-1:0]  Rd1,
   output logic [DATA_W-1:0]  Rd2,
   output logic               en_and,
   output logic               en_orr,
   output logic               en_xor,
   output logic               en_add,
   input  logic [DATA_W-1:0]  alu_result,
   output logic [DATA_W-1:0]  wb_data,
   output logic [ADDR_W-1:0]  wb_addr,
   output logic               done,
   input  logic [ADDR_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   state_e            state_q;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [ADDR_W-1:0] rs1_q;
   logic [ADDR_W-1:0] rs2_q;
   logic [DATA_W-1:0] rd1_q;
   logic [DATA_W-1:0] rd2_q;
   logic [DATA_W-1:0] res_q;
   logic [ADDR_W-1:0] wb_addr_q;
   logic [3:0]        en_q;
   logic              done_q;

   instr_t            instr_f;
   logic              accept;

   logic              rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_d;
   logic [DATA_W-1:0] rf_rd1;
   logic [DATA_W-1:0] rf_rd2;

   assign instr_f     = instr_t'(instr);
   assign instr_ready = (state_q == ST_IDLE) && !ld_en;
   assign accept      = instr_valid && instr_ready;

   // Writeback owns the port in WB; a direct load only gets it while IDLE.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = ld_addr;
      rf_wdata_d = ld_data;
      if (state_q == ST_WB) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = wb_addr_q;
         rf_wdata_d = res_q;
      end else if (state_q == ST_IDLE && ld_en) begin
         rf_we_d    = 1'b1;
      end
   end

   alu_regfile #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT),
      .ADDR_W  (ADDR_W)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .we_i       (rf_we_d),
      .waddr_i    (rf_waddr_d),
      .wdata_i    (rf_wdata_d),
      .raddr1_i   (rs1_q),
      .raddr2_i   (rs2_q),
      .dbg_addr_i (dbg_addr),
      .rdata1_o   (rf_rd1),
      .rdata2_o   (rf_rd2),
      .dbg_data_o (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         res_q     <= '0;
         wb_addr_q <= '0;
         en_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q    <= instr_f.op;
                  rd_q    <= instr_f.rd;
                  rs1_q   <= instr_f.rs1;
                  rs2_q   <= instr_f.rs2;
                  state_q <= ST_READ;
               end
            end
            ST_READ: begin
               rd1_q   <= rf_rd1;
               rd2_q   <= rf_rd2;
               en_q    <= op_to_en(op_q);
               state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               en_q      <= '0;
               res_q     <= alu_result;
               wb_addr_q <= rd_q;
               done_q    <= 1'b1;
               state_q   <= ST_WB;
            end
            ST_WB: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               en_q    <= '0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign Rd1     = rd1_q;
   assign Rd2     = rd2_q;
   assign en_and  = en_q[0];
   assign en_orr  = en_q[1];
   assign en_xor  = en_q[2];
   assign en_add  = en_q[3];
   assign wb_data = res_q;
   assign wb_addr = wb_addr_q;
   assign done    = done_q;

   a_en_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(en_q));
   a_done_in_wb: assert property (@(posedge clk) disable iff (rst) done_q |-> (state_q == ST_WB));

endmodule
